// File: rtl/mmm_seq_ctrl.sv
// Iteration-loop sequencer for a radix-2 carry-save Montgomery multiplier datapath.
// Walks IDLE -> LOAD -> RUN (single/double steps) -> CONV -> DONE.
module mmm_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int ITER     = WIDTH + 2,
    parameter int CONV_CYC = 1,
    parameter int IW       = $clog2(ITER + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          skip_in,
    output logic          busy,
    output logic          load,
    output logic          step_en,
    output logic          step_dbl,
    output logic [IW-1:0] idx,
    output logic          cnv_en,
    output logic          done,
    output logic [IW-1:0] run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CONV,
        S_DONE
    } state_t;

    localparam logic [IW:0] ITER_L    = (IW + 1)'(ITER);
    localparam logic [IW:0] ITER_M2_L = (IW + 1)'(ITER - 2);
    localparam logic [3:0]  CC_LAST   = 4'(CONV_CYC - 1);

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [IW-1:0] rc_reg, rc_next;
    logic [3:0]    cc_reg, cc_next;
    logic          dbl_w;
    logic [IW:0]   idx_sum;

    // Double steps are refused at the last index so idx can exceed ITER-1 by at most one.
    assign dbl_w   = (state_reg == S_RUN) && skip_in && ({1'b0, idx_reg} <= ITER_M2_L);
    assign idx_sum = {1'b0, idx_reg} + (dbl_w ? (IW + 1)'(2) : (IW + 1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            rc_reg    <= '0;
            cc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            rc_reg    <= rc_next;
            cc_reg    <= cc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        rc_next    = rc_reg;
        cc_next    = cc_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    idx_next   = '0;
                    rc_next    = '0;
                end
            end
            S_LOAD: begin
                state_next = S_RUN;
                idx_next   = '0;
                rc_next    = '0;
            end
            S_RUN: begin
                idx_next = idx_sum[IW-1:0];
                rc_next  = rc_reg + IW'(1);
                if (idx_sum >= ITER_L) begin
                    state_next = S_CONV;
                    cc_next    = '0;
                end
            end
            S_CONV: begin
                if (cc_reg == CC_LAST) begin
                    state_next = S_DONE;
                end else begin
                    cc_next = cc_reg + 4'd1;
                end
            end
            S_DONE: begin
                // idx returns to 0 so IDLE presents an all-zero index.
                state_next = S_IDLE;
                idx_next   = '0;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        load       = 1'b0;
        step_en    = 1'b0;
        cnv_en     = 1'b0;
        done       = 1'b0;
        step_dbl   = dbl_w;
        idx        = idx_reg;
        run_cycles = rc_reg;
        unique case (state_reg)
            S_LOAD: begin
                busy = 1'b1;
                load = 1'b1;
            end
            S_RUN: begin
                busy    = 1'b1;
                step_en = 1'b1;
            end
            S_CONV: begin
                busy   = 1'b1;
                cnv_en = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
